// File: rtl/branch_target_unit.sv
// rtl/branch_target_unit.sv - registered branch/jump target unit with handshake, flush and saturating stats
module branch_target_unit #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int JIDX_W = 26,
  parameter int SHIFT  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [DATA_W-1:0] pc_plus_4,
  input  logic [IMM_W-1:0]  imm,
  input  logic [JIDX_W-1:0] jidx,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] target,
  output logic              taken,
  output logic              link_we,
  output logic [DATA_W-1:0] link_addr,
  output logic              misalign,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [2:0] MODE_BEQ = 3'b001;
  localparam logic [2:0] MODE_BNE = 3'b010;
  localparam logic [2:0] MODE_J   = 3'b011;
  localparam logic [2:0] MODE_JAL = 3'b100;
  localparam logic [2:0] MODE_JR  = 3'b101;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              accept;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] br_target;
  logic [DATA_W-1:0] j_target;
  logic [DATA_W-1:0] nxt_target;
  logic              nxt_taken;
  logic              nxt_link_we;
  logic [DATA_W-1:0] nxt_link_addr;
  logic              nxt_misalign;
  logic              is_branch;

  // A new request may enter only when the result slot is free or being drained;
  // flush blocks entry so a squashed instruction never lands in the register.
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign imm_sext  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign br_target = pc_plus_4 + (imm_sext << SHIFT);
  assign j_target  = {pc_plus_4[DATA_W-1:JIDX_W+SHIFT], jidx, {SHIFT{1'b0}}};

  // Decode the mode into the next result; not-taken always falls through to pc_plus_4.
  always_comb begin
    nxt_taken     = 1'b0;
    nxt_target    = pc_plus_4;
    nxt_link_we   = 1'b0;
    nxt_link_addr = '0;
    is_branch     = 1'b0;
    case (in_mode)
      MODE_BEQ: begin
        is_branch = 1'b1;
        nxt_taken = (rs_val == rt_val);
        if (nxt_taken) nxt_target = br_target;
      end
      MODE_BNE: begin
        is_branch = 1'b1;
        nxt_taken = (rs_val != rt_val);
        if (nxt_taken) nxt_target = br_target;
      end
      MODE_J: begin
        nxt_taken  = 1'b1;
        nxt_target = j_target;
      end
      MODE_JAL: begin
        nxt_taken     = 1'b1;
        nxt_target    = j_target;
        nxt_link_we   = 1'b1;
        nxt_link_addr = pc_plus_4;
      end
      MODE_JR: begin
        nxt_taken  = 1'b1;
        nxt_target = rs_val;
      end
      default: begin
        nxt_taken = 1'b0;
      end
    endcase
    // Only a register-sourced target can be misaligned; the target itself is passed through.
    nxt_misalign = nxt_taken && (|nxt_target[SHIFT-1:0]);
  end

  // Result register: flush drops, accept loads (also covers drain+accept), drain clears valid only.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      target    <= '0;
      taken     <= 1'b0;
      link_we   <= 1'b0;
      link_addr <= '0;
      misalign  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      target    <= nxt_target;
      taken     <= nxt_taken;
      link_we   <= nxt_link_we;
      link_addr <= nxt_link_addr;
      misalign  <= nxt_misalign;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Branch statistics: count accepted conditional branches, saturating independently.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (accept && is_branch) begin
      if (branch_cnt != CNT_MAX) branch_cnt <= branch_cnt + CNT_ONE;
      if (nxt_taken && (taken_cnt != CNT_MAX)) taken_cnt <= taken_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_target_unit.sv
// tb/tb_branch_target_unit.sv - scoreboard bench for branch_target_unit
module tb_branch_target_unit;

  typedef struct packed {
    logic [31:0] target;
    logic        taken;
    logic        link_we;
    logic [31:0] link_addr;
    logic        misalign;
    logic [1:0]  bcnt;
    logic [1:0]  tcnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [31:0] pc_plus_4;
  logic [15:0] imm;
  logic [25:0] jidx;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] target;
  logic        taken;
  logic        link_we;
  logic [31:0] link_addr;
  logic        misalign;
  logic [1:0]  branch_cnt;
  logic [1:0]  taken_cnt;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  logic acc_seen = 1'b0;

  branch_target_unit #(.DATA_W(32), .IMM_W(16), .JIDX_W(26), .SHIFT(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .pc_plus_4(pc_plus_4), .imm(imm), .jidx(jidx), .rs_val(rs_val),
    .rt_val(rt_val), .out_valid(out_valid), .out_ready(out_ready), .target(target),
    .taken(taken), .link_we(link_we), .link_addr(link_addr), .misalign(misalign),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] t, input logic tk, input logic lw,
                              input logic [31:0] la, input logic mis,
                              input logic [1:0] bc, input logic [1:0] tc);
    exp_t e;
    e.target = t; e.taken = tk; e.link_we = lw; e.link_addr = la;
    e.misalign = mis; e.bcnt = bc; e.tcnt = tc;
    return e;
  endfunction

  // Accept detector: inputs change on negedge, so posedge sampling is race-free.
  initial forever begin
    @(posedge clk);
    acc_seen = in_valid && in_ready && !reset;
  end

  // Monitor: each newly loaded result is checked against the oldest expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (acc_seen) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result act=target:%h exp=no_pending_request", target);
      end else begin
        e = exp_q.pop_front();
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("target", target, e.target);
        chk("taken", 32'(taken), 32'(e.taken));
        chk("link_we", 32'(link_we), 32'(e.link_we));
        chk("link_addr", link_addr, e.link_addr);
        chk("misalign", 32'(misalign), 32'(e.misalign));
        chk("branch_cnt", 32'(branch_cnt), 32'(e.bcnt));
        chk("taken_cnt", 32'(taken_cnt), 32'(e.tcnt));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
  task automatic send(input logic [2:0] mode, input logic [31:0] pc, input logic [15:0] im,
                      input logic [25:0] ji, input logic [31:0] rs, input logic [31:0] rt,
                      input exp_t e);
    int n = 0;
    in_valid = 1'b1; in_mode = mode; pc_plus_4 = pc; imm = im; jidx = ji;
    rs_val = rs; rt_val = rt;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout act=in_ready:0 exp=in_ready:1");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mode = 3'b000; out_ready = 1'b1;
    pc_plus_4 = '0; imm = '0; jidx = '0; rs_val = '0; rt_val = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_target", target, 32'd0);
    chk("rst_taken", 32'(taken), 32'd0);
    chk("rst_link_we", 32'(link_we), 32'd0);
    chk("rst_link_addr", link_addr, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_branch_cnt", 32'(branch_cnt), 32'd0);
    chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // BEQ taken with negative offset, BNE not taken, BNE taken with max positive offset
    send(3'b001, 32'h0040_0004, 16'hFFFF, 26'h0, 32'd5, 32'd5,
         mk(32'h0040_0000, 1'b1, 1'b0, 32'h0, 1'b0, 2'd1, 2'd1));
    send(3'b010, 32'h0040_0010, 16'h0004, 26'h0, 32'd7, 32'd7,
         mk(32'h0040_0010, 1'b0, 1'b0, 32'h0, 1'b0, 2'd2, 2'd1));
    send(3'b010, 32'h0000_1000, 16'h7FFF, 26'h0, 32'd1, 32'd2,
         mk(32'h0002_0FFC, 1'b1, 1'b0, 32'h0, 1'b0, 2'd3, 2'd2));
    // J with all-ones index keeps only the top pc bits
    send(3'b011, 32'hA000_0008, 16'h1234, 26'h3FF_FFFF, 32'd0, 32'd0,
         mk(32'hAFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b0, 2'd3, 2'd2));
    in_valid = 1'b0;
    @(negedge clk); #1;
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_target_kept", target, 32'hAFFF_FFFC);
    @(negedge clk);

    send(3'b100, 32'h1000_0004, 16'h0000, 26'h010_0000, 32'd0, 32'd0,
         mk(32'h1040_0000, 1'b1, 1'b1, 32'h1000_0004, 1'b0, 2'd3, 2'd2));
    send(3'b111, 32'h0000_0040, 16'h0008, 26'h0, 32'd3, 32'd3,
         mk(32'h0000_0040, 1'b0, 1'b0, 32'h0, 1'b0, 2'd3, 2'd2));
    send(3'b101, 32'h0000_0100, 16'h0000, 26'h0, 32'h0040_0002, 32'd0,
         mk(32'h0040_0002, 1'b1, 1'b0, 32'h0, 1'b1, 2'd3, 2'd2));

    // Hold: consumer stalls, a pending request must not get in
    out_ready = 1'b0; in_mode = 3'b000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_target", target, 32'h0040_0002);
      chk("hold_misalign", 32'(misalign), 32'd1);
    end

    // Flush beats a simultaneous request that would otherwise bump taken_cnt
    flush = 1'b1; in_valid = 1'b1; in_mode = 3'b001; rs_val = 32'd4; rt_val = 32'd4;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_branch_cnt", 32'(branch_cnt), 32'd3);
    chk("flush_taken_cnt", 32'(taken_cnt), 32'd2);
    out_ready = 1'b1;
    @(negedge clk);

    // Clear the counters, then saturate both with back-to-back taken BEQs
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(3'b001, 32'h0000_0100, 16'h0001, 26'h0, 32'd9, 32'd9,
         mk(32'h0000_0104, 1'b1, 1'b0, 32'h0, 1'b0, 2'd1, 2'd1));
    send(3'b001, 32'h0000_0200, 16'h0001, 26'h0, 32'd9, 32'd9,
         mk(32'h0000_0204, 1'b1, 1'b0, 32'h0, 1'b0, 2'd2, 2'd2));
    send(3'b001, 32'h0000_0300, 16'h0001, 26'h0, 32'd9, 32'd9,
         mk(32'h0000_0304, 1'b1, 1'b0, 32'h0, 1'b0, 2'd3, 2'd3));
    send(3'b001, 32'h0000_0400, 16'h0001, 26'h0, 32'd9, 32'd9,
         mk(32'h0000_0404, 1'b1, 1'b0, 32'h0, 1'b0, 2'd3, 2'd3));
    send(3'b001, 32'h0000_0500, 16'h0001, 26'h0, 32'd9, 32'd9,
         mk(32'h0000_0504, 1'b1, 1'b0, 32'h0, 1'b0, 2'd3, 2'd3));
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);

    // Reset while a result is held
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_target", target, 32'd0);
    chk("mid_rst_taken", 32'(taken), 32'd0);
    chk("mid_rst_link_addr", link_addr, 32'd0);
    chk("mid_rst_branch_cnt", 32'(branch_cnt), 32'd0);
    chk("mid_rst_taken_cnt", 32'(taken_cnt), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    send(3'b001, 32'h0000_0600, 16'h0010, 26'h0, 32'd1, 32'd2,
         mk(32'h0000_0600, 1'b0, 1'b0, 32'h0, 1'b0, 2'd1, 2'd0));
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
